// File: rtl/input_sram_pkg.sv
// Shared types and constants for the ping-pong input SRAM controller.
package input_sram_pkg;

    localparam int unsigned NUM_BANKS = 8;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DEPTH     = 128;
    localparam int unsigned CNT_W     = 11;
    localparam int unsigned BANK_W    = 3;
    localparam int unsigned IDX_W     = 10;
    localparam int unsigned MAX_WORDS = NUM_BANKS * DEPTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_FULL,
        ST_DRAIN,
        ST_FLUSH
    } input_sram_ctrl_state_e;

    // Physical location of a linear beat index inside a bank set
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BANK_W-1:0] bank;
    } beat_loc_t;

    // Beats go round-robin across banks: low bits pick the bank, high bits the row
    function automatic beat_loc_t locate_beat(input logic [IDX_W-1:0] k);
        beat_loc_t loc;
        loc.bank = k[2:0];
        loc.addr = k[9:3];
        return loc;
    endfunction

endpackage

// File: rtl/input_sram_rd_pipe.sv
// Read-issue and out_valid tracking for the drain path (1-cycle SRAM latency).
module input_sram_rd_pipe
    import input_sram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rd_en,
    input  logic out_ready,
    output logic rd_issue,
    output logic out_valid,
    output logic rd_done
);

    logic valid_q;

    // A new row may be read only when the output slot is empty or being emptied
    always_comb begin
        rd_issue  = rd_en && (!valid_q || out_ready);
        rd_done   = valid_q && out_ready;
        out_valid = valid_q;
    end

    // Output slot occupancy: filled by an issue, emptied by a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (rd_issue) begin
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/input_sram_pingpong_ctrl.sv
// Fill/drain sequencer for the 8-bank ping-pong input SRAM.
// Optional macro INPUT_SRAM_PERF_EN adds saturating stall and drain counters.
module input_sram_pingpong_ctrl
    import input_sram_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fill_start,
    input  logic [CNT_W-1:0]                   cfg_words,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_data,
    input  logic                               drain_start,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]   out_data,
    output logic                               busy,
    output logic                               full,
    output logic                               cfg_err,
    output logic                               ping_pong_select,
    output logic [DATA_W-1:0]                  sram_DI  [0:NUM_BANKS-1],
    input  logic [DATA_W-1:0]                  sram_DO  [0:NUM_BANKS-1],
    output logic [ADDR_W-1:0]                  sram_A   [0:NUM_BANKS-1],
    output logic                               sram_CEN [0:NUM_BANKS-1],
    output logic                               sram_WEN [0:NUM_BANKS-1],
    output logic                               sram_OEN [0:NUM_BANKS-1]
`ifdef INPUT_SRAM_PERF_EN
    ,
    output logic [15:0]                        perf_stall_cnt,
    output logic [15:0]                        perf_drain_cnt
`endif
);

    input_sram_ctrl_state_e state_q;
    logic [IDX_W-1:0]  words_m1_q;
    logic [IDX_W-1:0]  beat_cnt_q;
    logic [ADDR_W-1:0] row_q;
    logic              sel_q;
    logic              cfg_err_q;

    logic      beat_acc;
    logic      rd_issue;
    logic      rd_done;
    logic      cfg_legal;
    beat_loc_t loc;

    input_sram_rd_pipe u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (state_q == ST_DRAIN),
        .out_ready (out_ready),
        .rd_issue  (rd_issue),
        .out_valid (out_valid),
        .rd_done   (rd_done)
    );

    // Status decode and fill-beat bookkeeping
    always_comb begin
        in_ready         = (state_q == ST_FILL);
        full             = (state_q == ST_FULL);
        busy             = (state_q != ST_IDLE) && (state_q != ST_FULL);
        cfg_err          = cfg_err_q;
        ping_pong_select = sel_q;
        beat_acc         = (state_q == ST_FILL) && in_valid;
        loc              = locate_beat(beat_cnt_q);
        cfg_legal        = (cfg_words != '0) && (cfg_words <= CNT_W'(MAX_WORDS));
    end

    // Phase sequencing, counters and ping-pong ownership
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            words_m1_q <= '0;
            beat_cnt_q <= '0;
            row_q      <= '0;
            sel_q      <= 1'b1;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (fill_start) begin
                        if (cfg_legal) begin
                            words_m1_q <= IDX_W'(cfg_words - CNT_W'(1));
                            beat_cnt_q <= '0;
                            state_q    <= ST_FILL;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end else if (drain_start) begin
                        cfg_err_q <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (fill_start || drain_start) cfg_err_q <= 1'b1;
                    if (beat_acc) begin
                        beat_cnt_q <= beat_cnt_q + IDX_W'(1);
                        if (beat_cnt_q == words_m1_q) state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (fill_start) cfg_err_q <= 1'b1;
                    if (drain_start) begin
                        row_q   <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fill_start || drain_start) cfg_err_q <= 1'b1;
                    if (rd_issue) begin
                        row_q <= row_q + ADDR_W'(1);
                        // last row index is (words-1)/8 == ceil(words/8)-1
                        if (row_q == words_m1_q[9:3]) state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (fill_start || drain_start) cfg_err_q <= 1'b1;
                    if (rd_done) begin
                        sel_q   <= ~sel_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // SRAM port drive: one bank written per accepted beat, all banks read per row
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            sram_CEN[b] = 1'b1;
            sram_WEN[b] = 1'b1;
            sram_OEN[b] = 1'b1;
            sram_A[b]   = '0;
            sram_DI[b]  = '0;
            if (beat_acc && (loc.bank == BANK_W'(b))) begin
                sram_CEN[b] = 1'b0;
                sram_WEN[b] = 1'b0;
                sram_A[b]   = loc.addr;
                sram_DI[b]  = in_data;
            end
            if ((state_q == ST_DRAIN) || (state_q == ST_FLUSH)) begin
                sram_OEN[b] = 1'b0;
                if (rd_issue) begin
                    sram_CEN[b] = 1'b0;
                    sram_A[b]   = row_q;
                end
            end
        end
    end

    // Row data comes straight from the SRAM outputs, which hold while stalled
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            out_data[b] = sram_DO[b];
        end
    end

`ifdef INPUT_SRAM_PERF_EN
    logic stall_evt;
    logic drain_evt;

    always_comb begin
        stall_evt = ((state_q == ST_FILL) && !in_valid) ||
                    (((state_q == ST_DRAIN) || (state_q == ST_FLUSH)) && out_valid && !out_ready);
        drain_evt = (state_q == ST_FLUSH) && rd_done;
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_drain_cnt <= '0;
        end else begin
            if (stall_evt && (perf_stall_cnt != 16'hFFFF)) perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (drain_evt && (perf_drain_cnt != 16'hFFFF)) perf_drain_cnt <= perf_drain_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_sram_pingpong_ctrl.sv
// Self-checking bench for input_sram_pingpong_ctrl with a two-set SRAM model.
module tb_input_sram_pingpong_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1;
    logic               fill_start = 1'b0;
    logic               drain_start = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [10:0]        cfg_words = '0;
    logic [127:0]       in_data = '0;
    logic               in_ready, out_valid, busy, full, cfg_err, ping_pong_select;
    logic [7:0][127:0]  out_data;
    logic [127:0]       sram_DI  [0:7];
    logic [127:0]       sram_DO  [0:7];
    logic [6:0]         sram_A   [0:7];
    logic               sram_CEN [0:7];
    logic               sram_WEN [0:7];
    logic               sram_OEN [0:7];
`ifdef INPUT_SRAM_PERF_EN
    logic [15:0]        perf_stall_cnt, perf_drain_cnt;
`endif

    input_sram_pingpong_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .fill_start       (fill_start),
        .cfg_words        (cfg_words),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .drain_start      (drain_start),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .busy             (busy),
        .full             (full),
        .cfg_err          (cfg_err),
        .ping_pong_select (ping_pong_select),
        .sram_DI          (sram_DI),
        .sram_DO          (sram_DO),
        .sram_A           (sram_A),
        .sram_CEN         (sram_CEN),
        .sram_WEN         (sram_WEN),
        .sram_OEN         (sram_OEN)
`ifdef INPUT_SRAM_PERF_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_drain_cnt   (perf_drain_cnt)
`endif
    );

    // Two bank sets; ping_pong_select=1 maps to set index 0 (A), 0 to set index 1 (B)
    logic [127:0] mem [0:1][0:7][0:127];

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (sram_CEN[b] == 1'b0) begin
                if (sram_WEN[b] == 1'b0) mem[!ping_pong_select][b][sram_A[b]] <= sram_DI[b];
                else                     sram_DO[b] <= mem[!ping_pong_select][b][sram_A[b]];
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_FILL = 1, P_FULL = 2, P_DRAIN = 3;
    logic [127:0] beats [0:1023];
    int   m_phase = P_IDLE;
    int   m_words = 0, m_k = 0, m_rows = 0, m_hs = 0;
    logic m_sel = 1'b1, m_err = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0][127:0] prev_data;
    int   fill_writes = 0, last_w_bank = -1, last_w_addr = -1;

    always @(negedge clk) begin
        logic [7:0] cen_v, wen_v, oen_v, ecen;
        logic [2:0] kb;
        logic nerr;
        int idx;
        for (int b = 0; b < 8; b++) begin
            cen_v[b] = sram_CEN[b];
            wen_v[b] = sram_WEN[b];
            oen_v[b] = sram_OEN[b];
        end
        if (rst) begin
            m_phase = P_IDLE; m_sel = 1'b1; m_err = 1'b0;
            m_k = 0; m_hs = 0; prev_stall = 1'b0;
        end else begin
            chk("in_ready", 128'(in_ready), 128'(m_phase == P_FILL));
            chk("full",     128'(full),     128'(m_phase == P_FULL));
            chk("busy",     128'(busy),     128'(m_phase == P_FILL || m_phase == P_DRAIN));
            chk("select",   128'(ping_pong_select), 128'(m_sel));
            chk("cfg_err",  128'(cfg_err),  128'(m_err));
            if (m_phase != P_DRAIN) chk("out_valid_quiet", 128'(out_valid), 128'(0));
            if (m_phase == P_FILL && in_valid) begin
                kb = 3'(m_k % 8);
                ecen = 8'hFF; ecen[kb] = 1'b0;
                chk("fill_cen",  128'(cen_v), 128'(ecen));
                chk("fill_wen",  128'(wen_v), 128'(ecen));
                chk("fill_addr", 128'(sram_A[kb]), 128'(m_k / 8));
                chk("fill_data", sram_DI[kb], beats[m_k]);
                fill_writes++; last_w_bank = m_k % 8; last_w_addr = m_k / 8;
            end else if (m_phase != P_DRAIN) begin
                chk("quiet_cen", 128'(cen_v), 128'(8'hFF));
            end
            if (m_phase == P_DRAIN) begin
                chk("drain_oen", 128'(oen_v), 128'(0));
                chk("drain_wen", 128'(wen_v), 128'(8'hFF));
                if (out_valid && !out_ready) chk("stall_cen", 128'(cen_v), 128'(8'hFF));
                if (prev_stall) begin
                    chk("stall_valid", 128'(out_valid), 128'(1));
                    for (int b = 0; b < 8; b++) chk("stall_hold", out_data[b], prev_data[b]);
                end
                if (out_valid && out_ready) begin
                    for (int b = 0; b < 8; b++) begin
                        idx = m_hs * 8 + b;
                        if (idx < m_words) chk("row_data", out_data[b], beats[idx]);
                    end
                    m_hs++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            nerr = 1'b0;
            case (m_phase)
                P_IDLE: begin
                    if (fill_start) begin
                        if (cfg_words >= 11'd1 && cfg_words <= 11'd1024) begin
                            m_words = int'(cfg_words); m_k = 0; m_phase = P_FILL;
                        end else nerr = 1'b1;
                    end else if (drain_start) nerr = 1'b1;
                end
                P_FILL: begin
                    if (fill_start || drain_start) nerr = 1'b1;
                    if (in_valid) begin
                        m_k++;
                        if (m_k == m_words) m_phase = P_FULL;
                    end
                end
                P_FULL: begin
                    if (fill_start) nerr = 1'b1;
                    if (drain_start) begin
                        m_phase = P_DRAIN; m_hs = 0; m_rows = (m_words + 7) / 8;
                    end
                end
                default: begin
                    if (fill_start || drain_start) nerr = 1'b1;
                    if (out_valid && out_ready && m_hs == m_rows) begin
                        m_phase = P_IDLE; m_sel = ~m_sel;
                    end
                end
            endcase
            m_err = nerr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic illegal(input bit is_fill, input int words);
        fill_start = is_fill; drain_start = !is_fill; cfg_words = 11'(words);
        tick();
        fill_start = 1'b0; drain_start = 1'b0;
        @(negedge clk);
        chk("illegal_err_pulse", 128'(cfg_err), 128'(1));
        chk("illegal_stays_idle", 128'(busy | full), 128'(0));
        tick();
    endtask

    task automatic do_fill(input int words, input int gap, input bit with_drain);
        int k, cyc;
        bit acc;
        for (int i = 0; i < words; i++) beats[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        fill_start = 1'b1; drain_start = with_drain; cfg_words = 11'(words);
        tick();
        fill_start = 1'b0; drain_start = 1'b0;
        k = 0; cyc = 0;
        while (k < words && cyc < 4000) begin
            in_valid = !(gap != 0 && (cyc % gap) == gap - 1);
            in_data  = beats[k];
            @(negedge clk);
            if (cyc == 0 && with_drain) chk("dual_start_no_err", 128'(cfg_err), 128'(0));
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
        if (k < words) chk("fill_timeout", 128'(k), 128'(words));
    endtask

    task automatic do_drain(input bit stall_pat, input int rows, input int stop_after,
                            output int hs, output int vc);
        int cyc;
        bit done;
        bit pat [0:3];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        hs = 0; vc = 0; cyc = 0; done = 1'b0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        while (!done && cyc < 2000) begin
            out_ready = stall_pat ? pat[cyc % 4] : 1'b1;
            @(negedge clk);
            if (out_valid) vc++;
            if (out_valid && out_ready) begin
                hs++;
                if (hs == rows || hs == stop_after) done = 1'b1;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (!done) chk("drain_timeout", 128'(hs), 128'(rows));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs, vc, wr0;
        logic [7:0] cen_v;
        for (int s = 0; s < 2; s++)
            for (int b = 0; b < 8; b++)
                for (int a = 0; a < 128; a++) mem[s][b][a] = '0;
        for (int b = 0; b < 8; b++) sram_DO[b] = '0;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",   128'(busy), 128'(0));
        chk("reset_full",   128'(full), 128'(0));
        chk("reset_select", 128'(ping_pong_select), 128'(1));
        tick();

        illegal(1'b1, 0);
        illegal(1'b1, 1025);
        illegal(1'b0, 0);

        // 16-word fill, then a rejected fill_start while FULL, then a free-flowing drain
        wr0 = fill_writes;
        do_fill(16, 0, 1'b0);
        @(negedge clk);
        chk("fill16_full",   128'(full), 128'(1));
        chk("fill16_writes", 128'(fill_writes - wr0), 128'(16));
        tick();
        fill_start = 1'b1; cfg_words = 11'd8;
        tick();
        fill_start = 1'b0;
        @(negedge clk);
        chk("fill_in_full_err", 128'(cfg_err), 128'(1));
        chk("fill_in_full_keeps_full", 128'(full), 128'(1));
        tick();
        do_drain(1'b0, 2, 0, hs, vc);
        @(negedge clk);
        chk("drain16_handshakes", 128'(hs), 128'(2));
        chk("drain16_valid_cycles", 128'(vc), 128'(2));
        chk("drain16_select", 128'(ping_pong_select), 128'(0));
        tick();

        // 20 words with loader gaps, drained with out_ready pattern 1,0,0,1
        do_fill(20, 3, 1'b0);
        do_drain(1'b1, 3, 0, hs, vc);
        @(negedge clk);
        chk("drain20_handshakes", 128'(hs), 128'(3));
        chk("drain20_select", 128'(ping_pong_select), 128'(1));
        tick();

        // Maximum fill: last beat must land at bank 7, row 127
        do_fill(1024, 7, 1'b0);
        @(negedge clk);
        chk("fill1024_last_bank", 128'(last_w_bank), 128'(7));
        chk("fill1024_last_addr", 128'(last_w_addr), 128'(127));
        chk("fill1024_full", 128'(full), 128'(1));
        tick();
        do_drain(1'b0, 128, 0, hs, vc);
        @(negedge clk);
        chk("drain1024_rows", 128'(hs), 128'(128));
        chk("drain1024_select", 128'(ping_pong_select), 128'(0));
        tick();

        // Reset in the middle of a drain
        do_fill(64, 0, 1'b0);
        do_drain(1'b0, 8, 5, hs, vc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 8; b++) cen_v[b] = sram_CEN[b];
        chk("rst_mid_busy",      128'(busy), 128'(0));
        chk("rst_mid_full",      128'(full), 128'(0));
        chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_cen",       128'(cen_v), 128'(8'hFF));
        chk("rst_mid_select",    128'(ping_pong_select), 128'(1));
        tick();

        // Simultaneous fill_start and drain_start in IDLE: fill wins silently
        do_fill(8, 0, 1'b1);
        do_drain(1'b0, 1, 0, hs, vc);
        @(negedge clk);
        chk("drain8_handshakes", 128'(hs), 128'(1));
        chk("drain8_select", 128'(ping_pong_select), 128'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_sram_pingpong_ctrl.md
Name: input_sram_pingpong_ctrl

Overview:
Sequences the 8-bank ping-pong input SRAM block through fill and drain phases. Accepts a 128-bit loader stream and scatters beats round-robin across the 8 banks. After a drain request, sweeps all 8 banks row by row toward the PE array. Owns ping_pong_select and toggles it after each completed drain, so the next fill lands in the other bank set.

Parameters:
NUM_BANKS, 8, banks per bank set
DATA_W, 128, SRAM word width
ADDR_W, 7, SRAM address width
DEPTH, 128, words per bank
CNT_W, 11, width of cfg_words (covers NUM_BANKS*DEPTH = 1024)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fill_start  in  1  one-cycle request to begin a fill
cfg_words  in  CNT_W  beats in this fill, legal range 1..1024; sampled on an accepted fill_start
in_valid  in  1  loader beat valid
in_ready  out  1  loader beat accepted when in_valid && in_ready
in_data  in  DATA_W  loader beat
drain_start  in  1  one-cycle request to begin a drain
out_valid  out  1  row valid toward PE
out_ready  in  1  PE accepts row
out_data  out  DATA_W x NUM_BANKS  row data, one word per bank
busy  out  1  state != IDLE && state != FULL
full  out  1  state == FULL
cfg_err  out  1  one-cycle pulse: illegal cfg_words or start ignored
ping_pong_select  out  1  1 selects bank set A, 0 selects bank set B
sram_DI  out  DATA_W [0:NUM_BANKS-1]  write data
sram_DO  in  DATA_W [0:NUM_BANKS-1]  read data
sram_A  out  ADDR_W [0:NUM_BANKS-1]  address
sram_CEN / sram_WEN / sram_OEN  out  1 [0:NUM_BANKS-1]  active-low controls

Behaviour:
- Clocking and reset: single clock, clk. rst is synchronous, active-high.
- Reset values: state=IDLE, ping_pong_select=1, in_ready=0, out_valid=0, full=0, busy=0, cfg_err=0. All CEN/WEN/OEN=1; A=0; DI=0; counters=0.
- States: IDLE, FILL, FULL, DRAIN, FLUSH.
- IDLE:
  - fill_start with 1<=cfg_words<=1024: latch words; beat_cnt=0; go to FILL.
  - fill_start with an illegal cfg_words: cfg_err pulse, stay in IDLE.
  - drain_start in IDLE: cfg_err pulse, ignored.
- FILL:
  - in_ready=1.
  - Each accepted beat k: bank = k mod 8, addr = k div 8.
  - That bank gets CEN=0, WEN=0, DI=in_data, A=addr in the same cycle. All other banks hold CEN=1.
  - When the beat with k = words-1 is accepted, go to FULL next cycle; in_ready drops that cycle.
- FULL: full=1, idle SRAM. drain_start: rows = ceil(words/8), row=0, go to DRAIN.
- DRAIN:
  - Read is issued when (!out_valid || out_ready): all 8 banks CEN=0, WEN=1, OEN=0, A=row; then row++.
  - Last row (row = rows-1) is still issued in DRAIN; after issuing it, go to FLUSH.
  - Banks past words in the last row are still read. Their contents are don't-care; the consumer masks them.
- Read pipeline:
  - Read latency is 1. out_valid is set the cycle after an issue and cleared on out_valid && out_ready with no new issue.
  - out_data = sram_DO, passed combinationally.
  - While out_valid && !out_ready: CEN=1, and the SRAM holds Q, so out_data stays stable.
- FLUSH:
  - Wait for the final out_valid && out_ready.
  - Then toggle ping_pong_select and go to IDLE.
  - OEN stays 0 until the handshake.
- Boundary cases:
  - fill_start or drain_start outside its legal state: cfg_err pulse, no state change.
  - Simultaneous fill_start and drain_start in IDLE: the fill wins; no cfg_err for the drain.
  - cfg_words=1024: beat 1023 goes to bank 7, addr 127; no wrap.
  - rst mid-FILL or mid-DRAIN: immediate return to the reset values, including ping_pong_select=1. SRAM contents are not cleared.
- ping_pong_select changes only on FLUSH completion, never mid-transaction.

Optional Feature:
INPUT_SRAM_PERF_EN
- Defined:
  - Adds output perf_stall_cnt [15:0]: cycles in FILL with !in_valid, plus cycles in DRAIN/FLUSH with out_valid && !out_ready.
  - Adds output perf_drain_cnt [15:0]: completed drains.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package input_sram_pkg:
  - state enum input_sram_ctrl_state_e.
  - NUM_BANKS, DATA_W, ADDR_W, DEPTH, MAX_WORDS=1024.
  - bank-index and address slicing helpers (k[2:0] and k[9:3]).
- One sub-module, input_sram_rd_pipe: read-issue/out_valid tracking and stall hold. The FSM, counters and fill path stay in the top module.

Test Plan:
- Fill, cfg_words=16, in_valid continuous: 16 write cycles. Banks 0..7 written at addr 0, then at addr 1. Enters FULL on cycle 17, full=1.
- Drain after the 16-word fill, out_ready=1: reads at A=0 then A=1 in consecutive cycles. out_valid high 2 cycles, with data equal to the written beats. ping_pong_select 1->0 one cycle after the last handshake.
- Drain with out_ready toggled 1,0,0,1: no CEN=0 while stalled; out_data unchanged across the stall. Exactly ceil(words/8) handshakes.
- cfg_words=0 and cfg_words=1025: cfg_err pulses, state remains IDLE. drain_start in IDLE also gives cfg_err.
- cfg_words=1024, full fill then drain: last write is bank 7, addr 127. 128 rows drained, then select toggles. A second cycle targets set B, and select returns to 1.
- rst asserted during DRAIN at row 5: next cycle state=IDLE, out_valid=0, all CEN=1, ping_pong_select=1.
